rat_checkpoint: RTL and testbench

- Register Alias Table (RAT) with branch checkpoint storage. This is the consumer of the branch buffer's Copy_RAT/tail_num and Paste_RAT/head_num outputs.
- Tracks, per architectural register, whether it is pending in the ROB and under which ROB tag.
- Snapshots the live table into slot tail_num on Copy_RAT.
- Restores the live table from slot head_num on Paste_RAT (mispredict recovery). Sits in the rename stage between decode and the ROB/reservation stations.

---
 rtl/rat_checkpoint_pkg.sv | 31 +++
 rtl/rat_checkpoint_if.sv | 34 +++
 rtl/rat_table.sv | 29 ++
 rtl/rat_checkpoint.sv | 87 ++++++++
 tb/tb_rat_checkpoint.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rat_checkpoint_pkg.sv
// rat_checkpoint_pkg: shared RAT entry types, sizing constants and the table update rule
package rat_checkpoint_pkg;
    localparam int NUM_ARCH = 32;
    localparam int TAG_W    = 5;
    localparam int NUM_CKPT = 8;
    localparam int CKPT_W   = 3;
    localparam int ARCH_W   = 5;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } rat_entry_t;

    typedef rat_entry_t [NUM_ARCH-1:0] rat_tbl_t;

    // Commit clears only when the tag still matches; a rename on the same register wins.
    function automatic rat_tbl_t rat_update(
        input rat_tbl_t          base,
        input logic              ren,
        input logic [ARCH_W-1:0] rrd,
        input logic [TAG_W-1:0]  rtag,
        input logic              cen,
        input logic [ARCH_W-1:0] crd,
        input logic [TAG_W-1:0]  ctag
    );
        rat_tbl_t t = base;
        if (cen && t[crd].busy && t[crd].tag == ctag) t[crd].busy = 1'b0;
        if (ren && rrd != '0) t[rrd] = '{busy: 1'b1, tag: rtag};
        return t;
    endfunction
endpackage

// File: rtl/rat_checkpoint_if.sv
// rat_checkpoint_if: rename/commit/checkpoint request bundle and lookup responses
interface rat_checkpoint_if;
    import rat_checkpoint_pkg::*;
    logic              rename_en;
    logic [ARCH_W-1:0] rename_rd;
    logic [TAG_W-1:0]  rename_tag;
    logic              commit_en;
    logic [ARCH_W-1:0] commit_rd;
    logic [TAG_W-1:0]  commit_tag;
    logic              Copy_RAT;
    logic [CKPT_W-1:0] tail_num;
    logic              Paste_RAT;
    logic [CKPT_W-1:0] head_num;
    logic [ARCH_W-1:0] rs1_addr;
    logic [ARCH_W-1:0] rs2_addr;
    logic              rs1_busy;
    logic [TAG_W-1:0]  rs1_tag;
    logic              rs2_busy;
    logic [TAG_W-1:0]  rs2_tag;
    logic [CKPT_W:0]   ckpt_count;
    logic              restore_done;
    logic              restore_err;

    modport master (
        output rename_en, rename_rd, rename_tag, commit_en, commit_rd, commit_tag,
        output Copy_RAT, tail_num, Paste_RAT, head_num, rs1_addr, rs2_addr,
        input  rs1_busy, rs1_tag, rs2_busy, rs2_tag, ckpt_count, restore_done, restore_err
    );
    modport slave (
        input  rename_en, rename_rd, rename_tag, commit_en, commit_rd, commit_tag,
        input  Copy_RAT, tail_num, Paste_RAT, head_num, rs1_addr, rs2_addr,
        output rs1_busy, rs1_tag, rs2_busy, rs2_tag, ckpt_count, restore_done, restore_err
    );
endinterface

// File: rtl/rat_table.sv
// rat_table: one NUM_ARCH-entry alias table with rename write, commit clear and bulk load
module rat_table
    import rat_checkpoint_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rename_en_i,
    input  logic [ARCH_W-1:0] rename_rd_i,
    input  logic [TAG_W-1:0]  rename_tag_i,
    input  logic              commit_en_i,
    input  logic [ARCH_W-1:0] commit_rd_i,
    input  logic [TAG_W-1:0]  commit_tag_i,
    input  logic              load_en_i,
    input  rat_tbl_t          load_data_i,
    output rat_tbl_t          table_o
);
    rat_tbl_t table_q, table_d;

    // Commit clear is applied on top of loaded data so a restore never revives a retired tag.
    always_comb table_d = rat_update(load_en_i ? load_data_i : table_q, rename_en_i, rename_rd_i,
                                     rename_tag_i, commit_en_i, commit_rd_i, commit_tag_i);

    always_ff @(posedge clk) begin
        if (!rst) table_q <= '0;
        else      table_q <= table_d;
    end

    assign table_o = table_q;
endmodule

// File: rtl/rat_checkpoint.sv
// rat_checkpoint: register alias table with branch snapshot (Copy_RAT) and restore (Paste_RAT)
module rat_checkpoint
    import rat_checkpoint_pkg::*;
(
    input logic             clk,
    input logic             rst,
    rat_checkpoint_if.slave rat
);
    rat_tbl_t            live_q, live_next;
    rat_tbl_t            slot_q [NUM_CKPT];
    logic [NUM_CKPT-1:0] valid_q, valid_d;
    logic [CKPT_W:0]     count_q, count_d;
    logic                done_q, err_q;
    logic                hit, restore, copy;

    assign hit     = valid_q[rat.head_num];
    assign restore = rat.Paste_RAT && hit;
    assign copy    = rat.Copy_RAT && !rat.Paste_RAT;

    rat_table u_live (
        .clk          (clk),
        .rst          (rst),
        .rename_en_i  (rat.rename_en && !restore),
        .rename_rd_i  (rat.rename_rd),
        .rename_tag_i (rat.rename_tag),
        .commit_en_i  (rat.commit_en),
        .commit_rd_i  (rat.commit_rd),
        .commit_tag_i (rat.commit_tag),
        .load_en_i    (restore),
        .load_data_i  (slot_q[rat.head_num]),
        .table_o      (live_q)
    );

    // Snapshot source includes this cycle's rename so a branch's own link register is captured.
    always_comb live_next = rat_update(live_q, rat.rename_en, rat.rename_rd, rat.rename_tag,
                                       rat.commit_en, rat.commit_rd, rat.commit_tag);

    for (genvar i = 0; i < NUM_CKPT; i++) begin : g_slot
        rat_table u_slot (
            .clk          (clk),
            .rst          (rst),
            .rename_en_i  (1'b0),
            .rename_rd_i  ('0),
            .rename_tag_i ('0),
            .commit_en_i  (rat.commit_en),
            .commit_rd_i  (rat.commit_rd),
            .commit_tag_i (rat.commit_tag),
            .load_en_i    (copy && rat.tail_num == CKPT_W'(i)),
            .load_data_i  (live_next),
            .table_o      (slot_q[i])
        );
    end

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        if (restore) begin
            valid_d = '0;
            count_d = '0;
        end else if (copy) begin
            valid_d[rat.tail_num] = 1'b1;
            count_d = count_q + (CKPT_W+1)'(!valid_q[rat.tail_num]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            done_q  <= restore;
            err_q   <= rat.Paste_RAT && !hit;
        end
    end

    assign rat.rs1_busy     = rat.rs1_addr != '0 && live_q[rat.rs1_addr].busy;
    assign rat.rs1_tag      = rat.rs1_addr != '0 ? live_q[rat.rs1_addr].tag : '0;
    assign rat.rs2_busy     = rat.rs2_addr != '0 && live_q[rat.rs2_addr].busy;
    assign rat.rs2_tag      = rat.rs2_addr != '0 ? live_q[rat.rs2_addr].tag : '0;
    assign rat.ckpt_count   = count_q;
    assign rat.restore_done = done_q;
    assign rat.restore_err  = err_q;
endmodule

// File: tb/tb_rat_checkpoint.sv
// tb_rat_checkpoint: directed vector table plus randomized run against an array-based RAT model
module tb_rat_checkpoint;
    import rat_checkpoint_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    rat_checkpoint_if bus();
    rat_checkpoint dut (.clk(clk), .rst(rst), .rat(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit               m_busy [NUM_ARCH];
    logic [TAG_W-1:0] m_tag  [NUM_ARCH];
    bit               c_busy [NUM_CKPT][NUM_ARCH];
    logic [TAG_W-1:0] c_tag  [NUM_CKPT][NUM_ARCH];
    bit               m_vld  [NUM_CKPT];
    int               m_cnt;
    bit               m_done, m_err;

    typedef struct {
        bit ren; int rd; int tg;
        bit cen; int crd; int ctg;
        bit cp; int tail; bit ps; int head;
        int rs1; int rs2;
        int b1; int t1; int b2; int t2; int cnt; int dn; int er;
    } vec_t;
    vec_t vecs [$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_tick();
        bit               nb [NUM_ARCH];
        logic [TAG_W-1:0] nt [NUM_ARCH];
        bit               restore, err;
        int               h, tl, crd;
        if (!rst) begin
            for (int r = 0; r < NUM_ARCH; r++) begin
                m_busy[r] = 0;
                m_tag[r]  = '0;
                for (int k = 0; k < NUM_CKPT; k++) begin
                    c_busy[k][r] = 0;
                    c_tag[k][r]  = '0;
                end
            end
            for (int k = 0; k < NUM_CKPT; k++) m_vld[k] = 0;
            m_cnt = 0; m_done = 0; m_err = 0;
            return;
        end
        h   = int'(bus.head_num);
        tl  = int'(bus.tail_num);
        crd = int'(bus.commit_rd);
        restore = bus.Paste_RAT && m_vld[h];
        err     = bus.Paste_RAT && !m_vld[h];
        for (int r = 0; r < NUM_ARCH; r++) begin
            nb[r] = restore ? c_busy[h][r] : m_busy[r];
            nt[r] = restore ? c_tag[h][r]  : m_tag[r];
        end
        if (bus.commit_en && nb[crd] && nt[crd] == bus.commit_tag) nb[crd] = 0;
        if (!restore && bus.rename_en && bus.rename_rd != 0) begin
            nb[bus.rename_rd] = 1;
            nt[bus.rename_rd] = bus.rename_tag;
        end
        for (int k = 0; k < NUM_CKPT; k++)
            if (bus.commit_en && c_busy[k][crd] && c_tag[k][crd] == bus.commit_tag) c_busy[k][crd] = 0;
        if (bus.Copy_RAT && !bus.Paste_RAT) begin
            for (int r = 0; r < NUM_ARCH; r++) begin
                c_busy[tl][r] = nb[r];
                c_tag[tl][r]  = nt[r];
            end
            if (!m_vld[tl]) m_cnt++;
            m_vld[tl] = 1;
        end
        if (restore) begin
            for (int k = 0; k < NUM_CKPT; k++) m_vld[k] = 0;
            m_cnt = 0;
        end
        m_done = restore;
        m_err  = err;
        m_busy = nb;
        m_tag  = nt;
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rename_en = 0; bus.rename_rd = '0; bus.rename_tag = '0;
        bus.commit_en = 0; bus.commit_rd = '0; bus.commit_tag = '0;
        bus.Copy_RAT = 0; bus.tail_num = '0; bus.Paste_RAT = 0; bus.head_num = '0;
    endtask

    task automatic check_model();
        int a1, a2;
        a1 = int'(bus.rs1_addr);
        a2 = int'(bus.rs2_addr);
        chk("rnd_rs1_busy", int'(bus.rs1_busy), a1 != 0 ? int'(m_busy[a1]) : 0);
        chk("rnd_rs1_tag",  int'(bus.rs1_tag),  a1 != 0 ? int'(m_tag[a1])  : 0);
        chk("rnd_rs2_busy", int'(bus.rs2_busy), a2 != 0 ? int'(m_busy[a2]) : 0);
        chk("rnd_rs2_tag",  int'(bus.rs2_tag),  a2 != 0 ? int'(m_tag[a2])  : 0);
        chk("rnd_count",    int'(bus.ckpt_count),   m_cnt);
        chk("rnd_done",     int'(bus.restore_done), int'(m_done));
        chk("rnd_err",      int'(bus.restore_err),  int'(m_err));
    endtask

    initial begin
        idle_inputs();
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;

        // Reset dominates a rename presented while reset is low.
        rst = 0;
        bus.rename_en = 1; bus.rename_rd = 5; bus.rename_tag = 3; bus.rs1_addr = 5;
        tick();
        tick();
        chk("reset_busy",  int'(bus.rs1_busy), 0);
        chk("reset_tag",   int'(bus.rs1_tag), 0);
        chk("reset_count", int'(bus.ckpt_count), 0);
        chk("reset_done",  int'(bus.restore_done), 0);
        idle_inputs();
        rst = 1;

        // ren rd tg | cen crd ctg | cp tail ps head | rs1 rs2 | b1 t1 b2 t2 cnt dn er
        vecs.push_back('{1,5,7,  0,0,0, 0,0,0,0, 5,0, 1,7,0,0,   0,0,0});
        vecs.push_back('{0,0,0,  1,5,6, 0,0,0,0, 5,0, 1,7,0,0,   0,0,0});
        vecs.push_back('{0,0,0,  1,5,7, 0,0,0,0, 5,0, 0,7,0,0,   0,0,0});
        vecs.push_back('{1,1,4,  0,0,0, 1,2,0,0, 1,5, 1,4,0,7,   1,0,0});
        vecs.push_back('{1,1,9,  0,0,0, 0,0,0,0, 1,5, 1,9,0,7,   1,0,0});
        vecs.push_back('{0,0,0,  0,0,0, 0,0,1,2, 1,5, 1,4,0,7,   0,1,0});
        vecs.push_back('{0,0,0,  0,0,0, 0,0,0,0, 1,5, 1,4,0,7,   0,0,0});
        vecs.push_back('{1,3,5,  0,0,0, 0,0,0,0, 3,1, 1,5,1,4,   0,0,0});
        vecs.push_back('{0,0,0,  0,0,0, 1,0,0,0, 3,1, 1,5,1,4,   1,0,0});
        vecs.push_back('{0,0,0,  1,3,5, 0,0,0,0, 3,1, 0,5,1,4,   1,0,0});
        vecs.push_back('{1,3,12, 0,0,0, 0,0,0,0, 3,1, 1,12,1,4,  1,0,0});
        vecs.push_back('{0,0,0,  0,0,0, 0,0,1,0, 3,1, 0,5,1,4,   0,1,0});
        vecs.push_back('{1,7,2,  0,0,0, 1,4,0,0, 7,3, 1,2,0,5,   1,0,0});
        vecs.push_back('{0,0,0,  0,0,0, 0,0,1,6, 7,3, 1,2,0,5,   1,0,1});
        vecs.push_back('{0,0,0,  0,0,0, 0,0,0,0, 7,3, 1,2,0,5,   1,0,0});
        vecs.push_back('{1,9,11, 0,0,0, 1,1,1,4, 7,9, 1,2,0,0,   0,1,0});
        vecs.push_back('{0,0,0,  0,0,0, 0,0,1,1, 7,9, 1,2,0,0,   0,0,1});
        vecs.push_back('{1,0,13, 0,0,0, 0,0,0,0, 0,0, 0,0,0,0,   0,0,0});
        vecs.push_back('{0,0,0,  0,0,0, 1,3,0,0, 2,1, 0,0,1,4,   1,0,0});
        vecs.push_back('{1,2,1,  0,0,0, 1,3,0,0, 2,1, 1,1,1,4,   1,0,0});
        vecs.push_back('{0,0,0,  0,0,0, 0,0,1,3, 2,1, 1,1,1,4,   0,1,0});

        foreach (vecs[i]) begin
            bus.rename_en  = vecs[i].ren; bus.rename_rd = ARCH_W'(vecs[i].rd); bus.rename_tag = TAG_W'(vecs[i].tg);
            bus.commit_en  = vecs[i].cen; bus.commit_rd = ARCH_W'(vecs[i].crd); bus.commit_tag = TAG_W'(vecs[i].ctg);
            bus.Copy_RAT   = vecs[i].cp;  bus.tail_num  = CKPT_W'(vecs[i].tail);
            bus.Paste_RAT  = vecs[i].ps;  bus.head_num  = CKPT_W'(vecs[i].head);
            bus.rs1_addr   = ARCH_W'(vecs[i].rs1); bus.rs2_addr = ARCH_W'(vecs[i].rs2);
            tick();
            chk($sformatf("v%0d_rs1_busy", i), int'(bus.rs1_busy), vecs[i].b1);
            chk($sformatf("v%0d_rs1_tag", i),  int'(bus.rs1_tag),  vecs[i].t1);
            chk($sformatf("v%0d_rs2_busy", i), int'(bus.rs2_busy), vecs[i].b2);
            chk($sformatf("v%0d_rs2_tag", i),  int'(bus.rs2_tag),  vecs[i].t2);
            chk($sformatf("v%0d_count", i),    int'(bus.ckpt_count),   vecs[i].cnt);
            chk($sformatf("v%0d_done", i),     int'(bus.restore_done), vecs[i].dn);
            chk($sformatf("v%0d_err", i),      int'(bus.restore_err),  vecs[i].er);
        end

        // Reset arriving together with a valid restore must win.
        idle_inputs();
        bus.Copy_RAT = 1; bus.tail_num = 2;
        tick();
        chk("pre_rst_count", int'(bus.ckpt_count), 1);
        idle_inputs();
        bus.Paste_RAT = 1; bus.head_num = 2; bus.rs1_addr = 1;
        rst = 0;
        tick();
        chk("rst_paste_done",  int'(bus.restore_done), 0);
        chk("rst_paste_count", int'(bus.ckpt_count), 0);
        chk("rst_paste_busy",  int'(bus.rs1_busy), 0);
        idle_inputs();
        rst = 1;
        tick();

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(63) != 0);
            bus.rename_en  = 1'($urandom_range(1));
            bus.rename_rd  = ARCH_W'($urandom);
            bus.rename_tag = TAG_W'($urandom);
            bus.commit_en  = 1'($urandom_range(1));
            bus.commit_rd  = ARCH_W'($urandom);
            bus.commit_tag = ($urandom_range(3) != 0) ? m_tag[bus.commit_rd] : TAG_W'($urandom);
            bus.Copy_RAT   = ($urandom_range(3) == 0);
            bus.tail_num   = CKPT_W'($urandom);
            bus.Paste_RAT  = ($urandom_range(7) == 0);
            bus.head_num   = CKPT_W'($urandom);
            if (bus.Paste_RAT && !m_vld[bus.head_num]) begin
                bus.rename_en = 0;
                bus.commit_en = 0;
            end
            bus.rs1_addr = ARCH_W'($urandom);
            bus.rs2_addr = ARCH_W'($urandom);
            tick();
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
